// File: rtl/i_cache_if.sv
// Bus bundle between the CPU fetch stage, the instruction cache and the
// block-based instruction memory. The cache uses the slave view; the
// surrounding environment (CPU + memory) uses the master view.
interface i_cache_if;
  logic         READ_EN;
  logic [31:0]  ADDRESS;
  logic         BUSYWAIT;
  logic [31:0]  INSTRUCTION;
  logic         MEM_READ_EN;
  logic [27:0]  MEM_ADDR;
  logic         MEM_BUSYWAIT;
  logic [127:0] MEM_READ_DATA;

  modport slave (
    input  READ_EN, ADDRESS, MEM_BUSYWAIT, MEM_READ_DATA,
    output BUSYWAIT, INSTRUCTION, MEM_READ_EN, MEM_ADDR
  );

  modport master (
    output READ_EN, ADDRESS, MEM_BUSYWAIT, MEM_READ_DATA,
    input  BUSYWAIT, INSTRUCTION, MEM_READ_EN, MEM_ADDR
  );
endinterface

// File: rtl/i_cache.sv
// Direct-mapped read-only instruction cache with 16-byte lines.
// Hits are served combinationally; a miss stalls the CPU, reads one block
// from instruction memory and installs it before the access is retried.
module i_cache #(
  parameter int INDEX_BITS = 3
) (
  input  logic    CLK,
  input  logic    RESET,
  i_cache_if.slave bus
);

  localparam int TAG_BITS = 28 - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_t;

  state_t                state_q;
  logic                  mem_read_en_q;
  logic [27:0]           mem_addr_q;
  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [127:0]          data_mem [LINES];

  logic [INDEX_BITS-1:0] cpu_idx;
  logic [TAG_BITS-1:0]   cpu_tag;
  logic [1:0]            word_sel;
  logic [INDEX_BITS-1:0] fill_idx;
  logic                  hit;
  logic                  unused_byte_sel;

  assign cpu_idx         = bus.ADDRESS[4 +: INDEX_BITS];
  assign cpu_tag         = bus.ADDRESS[31 -: TAG_BITS];
  assign word_sel        = bus.ADDRESS[3:2];
  assign fill_idx        = mem_addr_q[INDEX_BITS-1:0];
  // Byte offset within a word is irrelevant for word-aligned fetches.
  assign unused_byte_sel = ^bus.ADDRESS[1:0];

  // Hit detection and instruction word select from the addressed line.
  always_comb begin
    hit             = bus.READ_EN & valid_q[cpu_idx] & (tag_mem[cpu_idx] == cpu_tag);
    bus.INSTRUCTION = 32'h0;
    if (hit) begin
      bus.INSTRUCTION = data_mem[cpu_idx][{word_sel, 5'd0} +: 32];
    end
    // Stall unless an idle cache is serving a hit; never stall without a request.
    bus.BUSYWAIT    = bus.READ_EN & ~((state_q == IDLE) & hit);
  end

  assign bus.MEM_READ_EN = mem_read_en_q;
  assign bus.MEM_ADDR    = mem_addr_q;

  // Miss-handling FSM: latch the block address, wait for the memory, install.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= IDLE;
      mem_read_en_q <= 1'b0;
      mem_addr_q    <= '0;
      valid_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.READ_EN && !hit) begin
            mem_addr_q    <= bus.ADDRESS[31:4];
            mem_read_en_q <= 1'b1;
            state_q       <= MEM_READ;
          end
        end
        MEM_READ: begin
          // Dropping the request here lets the memory's byte counter park at 0.
          if (!bus.MEM_BUSYWAIT) begin
            mem_read_en_q <= 1'b0;
            state_q       <= UPDATE;
          end
        end
        UPDATE: begin
          valid_q[fill_idx] <= 1'b1;
          state_q           <= IDLE;
        end
        default: begin
          mem_read_en_q <= 1'b0;
          state_q       <= IDLE;
        end
      endcase
    end
  end

  // Line storage: written only when a fill completes; never reset.
  always_ff @(posedge CLK) begin
    if (state_q == UPDATE) begin
      data_mem[fill_idx] <= bus.MEM_READ_DATA;
      tag_mem[fill_idx]  <= mem_addr_q[27 -: TAG_BITS];
    end
  end

endmodule

// File: doc/i_cache.md
Name: i_cache

Overview:
- Direct-mapped, read-only instruction cache between the CPU fetch stage and the block-based instruction memory.
- Serves 32-bit instructions to the CPU with zero-cycle hit latency.
- On a miss it stalls the CPU, fetches a 128-bit (16-byte) block from instruction memory using the memory's READ_EN/BUSYWAIT handshake, then installs the block.

Parameters:
- INDEX_BITS, 3, log2 of line count (8 lines). Block size is fixed at 16 bytes / 4 words.
- TAG_BITS, 25, equals 28 - INDEX_BITS. Derived; not overridden independently.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RESET  input  1  asynchronous, active-low reset (0 = reset).
- READ_EN  input  1  CPU fetch request.
- ADDRESS  input  32  CPU byte address: [31:7] tag, [6:4] index, [3:2] word select, [1:0] ignored.
- BUSYWAIT  output  1  CPU stall.
- INSTRUCTION  output  32  fetched instruction.
- MEM_READ_EN  output  1  block read request to instruction memory.
- MEM_ADDR  output  28  block address, equal to the byte address [31:4].
- MEM_BUSYWAIT  input  1  memory busy; low when the block is complete.
- MEM_READ_DATA  input  128  block data; byte k of the block is at bits [8k+7:8k].

Behaviour:
- Storage per line: valid bit, 25-bit tag, 128-bit data.
- Reset (RESET=0, asynchronous):
  - All valid bits cleared, state <= IDLE, MEM_READ_EN=0, MEM_ADDR=0.
  - Data and tag arrays are not cleared.
- HIT = READ_EN & valid[index] & (tag[index] == ADDRESS[31:7]). Combinational.
- INSTRUCTION = HIT ? data[index][32*w+31 : 32*w] : 32'h0, where w = ADDRESS[3:2]. Combinational.
- BUSYWAIT = READ_EN & ~(state==IDLE & HIT). BUSYWAIT=0 whenever READ_EN=0.
- FSM states:
  - IDLE:
    - Serves hits with no state change.
    - On READ_EN & ~HIT at posedge: latch MEM_ADDR <= ADDRESS[31:4], go to MEM_READ.
  - MEM_READ:
    - MEM_READ_EN=1 (registered output).
    - Stays while MEM_BUSYWAIT=1.
    - At the posedge where MEM_BUSYWAIT is sampled 0, the final byte lands in memory; go to UPDATE.
  - UPDATE:
    - MEM_READ_EN=0.
    - At posedge: data[idx] <= MEM_READ_DATA, tag[idx] <= MEM_ADDR[27:3], valid[idx] <= 1, where idx = MEM_ADDR[2:0]. Go to IDLE.
    - The next cycle is a hit if ADDRESS is unchanged.
- MEM_READ_EN is deasserted in UPDATE so the memory's byte counter stops at 0, ready for the next fill.
- Miss latency with the 16-cycle instruction memory:
  - 1 cycle IDLE detect + 16 cycles MEM_READ + 1 cycle UPDATE.
  - BUSYWAIT drops in the IDLE cycle after UPDATE (18 cycles after the miss cycle).
- The fill uses the latched MEM_ADDR. ADDRESS changes during MEM_READ/UPDATE do not alter the fill. After UPDATE, the current ADDRESS is re-evaluated and may miss again.
- READ_EN dropping mid-fill: the fill still completes and installs the line; BUSYWAIT reads 0 meanwhile.
- A replaced line is overwritten unconditionally; no write-back (read-only).
- Reset asserted mid-fill: immediate return to IDLE, MEM_READ_EN=0, no line installed. The top level resets the instruction memory on the same event.
- Index wrap: block addresses differing only in tag map to the same line and evict each other.

Test Plan:
- Reset then READ_EN=1, ADDRESS=32'h0000_0000 -> BUSYWAIT=1 immediately; MEM_READ_EN=1 with MEM_ADDR=28'h0 from the next cycle for 16 cycles; BUSYWAIT=0 18 cycles after request; INSTRUCTION = bytes 3..0 of memory.
- After that fill, ADDRESS=0x4, 0x8, 0xC on consecutive cycles -> BUSYWAIT=0 every cycle, INSTRUCTION = words 1,2,3 of the block, MEM_READ_EN stays 0.
- Fetch 0x0000_0080 (same index 0, tag 1) -> miss, MEM_ADDR=28'h8, line 0 replaced; refetch 0x0 -> misses again.
- During a miss on 0x10, change ADDRESS to 0x20 in the 5th MEM_READ cycle -> line 1 is installed with tag 0; after UPDATE, 0x20 misses and fills line 2.
- Assert RESET=0 during the 8th MEM_READ cycle -> MEM_READ_EN=0 asynchronously; after release, the original address misses again (valid bit was cleared).
- READ_EN=0 with arbitrary ADDRESS -> BUSYWAIT=0, INSTRUCTION=32'h0, MEM_READ_EN=0.
